height_digit_ctrl: RTL and testbench

- Renders the measured height as a fixed-position decimal readout on the pixel display.
- Accepts binary height samples through a valid/ready handshake and converts each to BCD iteratively, one shift per cycle.
- Holds the result until a frame boundary to prevent tearing.
- For each incoming pixel coordinate, drives digit select, col and row to the shared 8x16 glyph ROM bank and returns the 6-bit pixel colour.

---
 rtl/height_disp_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 64 ++++++
 rtl/height_digit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_height_digit_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/height_disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// height_disp_pkg : shared types and constants for the height readout
// Revision 1.0
// ---------------------------------------------------------------------------
package height_disp_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam logic [5:0] COLOR_WHITE = 6'b111111;
  localparam logic [5:0] COLOR_BLACK = 6'b000000;

  localparam int DEF_GLYPH_W = 8;
  localparam int DEF_GLYPH_H = 16;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2bcd_seq : iterative double-dabble converter, one shift per cycle
// Revision 1.0
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int VALUE_W    = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [BCD_W-1:0]         bcd_q, bcd_d, adj;
  logic [VALUE_W-1:0]       bin_q, bin_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     busy_q;
  logic [BCD_W+VALUE_W-1:0] shifted;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
    bcd_d   = shifted[BCD_W+VALUE_W-1:VALUE_W];
    bin_d   = shifted[VALUE_W-1:0];
  end

  // The result is presented combinationally on the final shift so the caller
  // can capture it on the same edge that ends the conversion.
  assign done_o = busy_q && (cnt_q == CNT_W'(VALUE_W - 1));
  assign bcd_o  = bcd_d;
  assign busy_o = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      bin_q  <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      bcd_q  <= '0;
      bin_q  <= value_i;
    end else if (busy_q) begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/height_digit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// height_digit_ctrl : decimal height readout rendered through a glyph ROM
// Revision 1.0
// ---------------------------------------------------------------------------
module height_digit_ctrl
  import height_disp_pkg::*;
#(
  parameter int VALUE_W    = 10,
  parameter int NUM_DIGITS = 3,
  parameter int ORIGIN_X   = 16,
  parameter int ORIGIN_Y   = 16,
  parameter int GLYPH_W    = DEF_GLYPH_W,
  parameter int GLYPH_H    = DEF_GLYPH_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               height_valid,
  input  logic [VALUE_W-1:0] height_value,
  output logic               height_ready,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [3:0]         glyph_digit,
  output logic [4:0]         glyph_col,
  output logic [4:0]         glyph_row,
  input  logic [5:0]         glyph_data,
  output logic [5:0]         pixel_out,
  output logic               pix_out_valid
);

  localparam int         BCD_W   = 4 * NUM_DIGITS;
  localparam int         MAX_VAL = 10 ** NUM_DIGITS - 1;
  localparam int         GW_LOG  = $clog2(GLYPH_W);
  localparam logic [10:0] X_LO   = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI   = 11'(ORIGIN_X + NUM_DIGITS * GLYPH_W);
  localparam logic [10:0] Y_LO   = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI   = 11'(ORIGIN_Y + GLYPH_H);

  state_t             state_q, state_d;
  logic               conv_start, conv_busy, conv_done, ready;
  logic [BCD_W-1:0]   conv_bcd;
  logic [VALUE_W-1:0] sat_value;
  logic [BCD_W-1:0]   pending_q, display_q;
  logic               pending_flag_q;

  assign sat_value = (32'(height_value) > 32'(MAX_VAL)) ? VALUE_W'(MAX_VAL) : height_value;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .value_i (sat_value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    ready      = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !conv_busy;
        if (height_valid && ready) begin
          conv_start = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: if (conv_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign height_ready = ready && !reset;

  // A conversion finishing on a frame boundary bypasses pending entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      display_q      <= '0;
    end else if (conv_done) begin
      pending_q <= conv_bcd;
      if (frame_start) begin
        display_q      <= conv_bcd;
        pending_flag_q <= 1'b0;
      end else begin
        pending_flag_q <= 1'b1;
      end
    end else if (frame_start && pending_flag_q) begin
      display_q      <= pending_q;
      pending_flag_q <= 1'b0;
    end
  end

  logic       in_box, sel_blank, lead_zero;
  logic [9:0] dx, dig_idx;
  logic [3:0] sel_digit, nib;

  always_comb begin
    in_box    = ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
    dx        = pix_x - 10'(ORIGIN_X);
    dig_idx   = dx >> GW_LOG;
    sel_digit = '0;
    sel_blank = 1'b0;
    lead_zero = 1'b1;
    nib       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib       = display_q[BCD_W-4-4*i +: 4];
      lead_zero = lead_zero && (nib == 4'd0);
      if (dig_idx == 10'(i)) begin
        sel_digit = nib;
        sel_blank = lead_zero && (i != NUM_DIGITS - 1);
      end
    end
  end

  logic s1_valid_q, s1_in_box_q, s1_blank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_digit <= '0;
      glyph_col   <= '0;
      glyph_row   <= '0;
      s1_valid_q  <= 1'b0;
      s1_in_box_q <= 1'b0;
      s1_blank_q  <= 1'b0;
    end else begin
      s1_valid_q  <= pix_valid;
      s1_in_box_q <= in_box;
      s1_blank_q  <= sel_blank;
      if (pix_valid && in_box) begin
        glyph_digit <= sel_digit;
        glyph_col   <= 5'(dx & 10'(GLYPH_W - 1));
        glyph_row   <= 5'(pix_y - 10'(ORIGIN_Y));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out     <= COLOR_WHITE;
      pix_out_valid <= 1'b0;
    end else begin
      pixel_out     <= (s1_in_box_q && !s1_blank_q) ? glyph_data : COLOR_WHITE;
      pix_out_valid <= s1_valid_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_height_digit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_height_digit_ctrl : directed + random bench against a decimal model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_height_digit_ctrl;

  logic       clk = 1'b0;
  logic       reset, height_valid, height_ready, frame_start, pix_valid, pix_out_valid;
  logic [9:0] height_value, pix_x, pix_y;
  logic [3:0] glyph_digit;
  logic [4:0] glyph_col, glyph_row;
  logic [5:0] glyph_data, pixel_out;

  int total = 0;
  int bad   = 0;
  int disp_m = 0, pend_m = 0;
  bit pflag_m = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] color(input int d, input int c, input int r);
    return 6'((d * 7 + c * 3 + r * 5) % 64);
  endfunction

  assign glyph_data = color(int'(glyph_digit), int'(glyph_col), int'(glyph_row));

  height_digit_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .height_valid  (height_valid),
    .height_value  (height_value),
    .height_ready  (height_ready),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .glyph_digit   (glyph_digit),
    .glyph_col     (glyph_col),
    .glyph_row     (glyph_row),
    .glyph_data    (glyph_data),
    .pixel_out     (pixel_out),
    .pix_out_valid (pix_out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pix(input int x, input int y);
    bit inb, blk;
    int idx, col, row, d, expect_pix;
    inb = (x >= 16) && (x < 40) && (y >= 16) && (y < 32);
    idx = (x - 16) / 8;
    col = (x - 16) % 8;
    row = y - 16;
    d   = (disp_m / pow10(2 - idx)) % 10;
    blk = (idx < 2) && (disp_m < pow10(2 - idx));
    pix_valid = 1'b1;
    pix_x = 10'(x);
    pix_y = 10'(y);
    tick();
    pix_valid = 1'b0;
    chk("lat_not_yet", 32'(pix_out_valid), 0);
    if (inb) begin
      chk("glyph_digit", 32'(glyph_digit), d);
      chk("glyph_col", 32'(glyph_col), col);
      chk("glyph_row", 32'(glyph_row), row);
    end
    tick();
    chk("out_valid", 32'(pix_out_valid), 1);
    expect_pix = (inb && !blk) ? int'(color(d, col, row)) : 63;
    chk("pixel_out", 32'(pixel_out), expect_pix);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (pflag_m) begin
      disp_m  = pend_m;
      pflag_m = 0;
    end
  endtask

  // inject_at / fs_at: busy-cycle index at which a stray height_valid or a
  // frame_start is raised for one cycle (-1 disables).
  task automatic send(input int v, input int inject_at, input int fs_at);
    int n = 0;
    while (!height_ready && n < 100) begin
      tick();
      n++;
    end
    if (!height_ready) chk("ready_timeout", 32'(height_ready), 1);
    height_valid = 1'b1;
    height_value = 10'(v);
    tick();
    height_valid = 1'b0;
    n = 0;
    while (!height_ready && n < 50) begin
      if (n == inject_at) begin
        height_valid = 1'b1;
        height_value = 10'd42;
      end
      if (n == fs_at) frame_start = 1'b1;
      tick();
      height_valid = 1'b0;
      frame_start  = 1'b0;
      n++;
    end
    chk("busy_cycles", n, 10);
    pend_m = (v > 999) ? 999 : v;
    if (fs_at == 9) begin
      disp_m  = pend_m;
      pflag_m = 0;
    end else begin
      pflag_m = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; height_valid = 1'b0; height_value = '0; frame_start = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(height_ready), 0);
    chk("rst_out_valid", 32'(pix_out_valid), 0);
    chk("rst_pixel", 32'(pixel_out), 63);
    chk("rst_digit", 32'(glyph_digit), 0);
    chk("rst_col", 32'(glyph_col), 0);
    chk("rst_row", 32'(glyph_row), 0);
    reset = 1'b0;
    check_pix(32, 17);
    check_pix(17, 17);

    send(125, -1, -1);
    check_pix(25, 18);
    frame();
    check_pix(25, 18);
    check_pix(17, 17);
    check_pix(33, 31);

    send(1000, -1, -1);
    frame();
    check_pix(16, 16);
    check_pix(39, 31);
    check_pix(27, 20);

    send(7, 4, -1);
    frame();
    check_pix(16, 20);
    check_pix(24, 20);
    check_pix(32, 20);

    send(250, -1, 9);
    check_pix(24, 16);
    frame();
    check_pix(16, 16);

    send(300, -1, -1);
    send(48, -1, -1);
    check_pix(24, 16);
    frame();
    check_pix(24, 16);
    check_pix(16, 16);
    check_pix(32, 16);

    check_pix(15, 20);
    check_pix(40, 20);
    check_pix(20, 15);
    check_pix(20, 32);

    for (int it = 0; it < 8; it++) begin
      send(int'($urandom_range(0, 1023)), -1, -1);
      repeat (2) check_pix(int'($urandom_range(10, 45)), int'($urandom_range(12, 35)));
      frame();
      repeat (3) check_pix(int'($urandom_range(14, 41)), int'($urandom_range(14, 33)));
    end
    send(563, -1, -1);
    frame();

    height_valid = 1'b1;
    height_value = 10'd555;
    tick();
    height_valid = 1'b0;
    pix_valid = 1'b1;
    pix_x = 10'd32;
    pix_y = 10'd20;
    repeat (4) tick();
    chk("pre_rst_valid", 32'(pix_out_valid), 1);
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(pix_out_valid), 0);
    chk("midrst_ready", 32'(height_ready), 0);
    reset = 1'b0;
    pix_valid = 1'b0;
    disp_m = 0; pend_m = 0; pflag_m = 0;
    tick();
    chk("postrst_ready", 32'(height_ready), 1);
    repeat (15) tick();
    frame();
    check_pix(32, 20);
    check_pix(16, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
